// File: rtl/booth_mul_iter_if.sv
// Operand/result bundle for booth_mul_iter. The design takes the slave modport
// and the requester the master modport. state_dbg mirrors the internal FSM state.
interface booth_mul_iter_if #(
    parameter int XLEN = 64
);
    // Handshake: a transfer happens on a rising clock edge where valid && ready.
    // The source holds valid and its payload steady until that edge.
    // The sink may raise or drop ready at any time.
    // flush overrides both directions and returns the unit to idle.
    logic            in_valid;
    logic            in_ready;
    logic            flush;
    logic            mulw;
    logic [1:0]      mul_signed;
    logic [XLEN-1:0] multiplicand;
    logic [XLEN-1:0] multiplier;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result_hi;
    logic [XLEN-1:0] result_lo;
    logic [1:0]      state_dbg;

    modport master (
        output in_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
        input  in_ready, out_valid, result_hi, result_lo, state_dbg
    );

    modport slave (
        input  in_valid, flush, mulw, mul_signed, multiplicand, multiplier, out_ready,
        output in_ready, out_valid, result_hi, result_lo, state_dbg
    );
endinterface

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier retiring STEPS digits per cycle, with MULW support.
// Define MUL_EARLY_OUT_EN to finish as soon as the remaining multiplier digits are all zero.
module booth_mul_iter #(
    parameter int XLEN  = 64,
    parameter int STEPS = 1
) (
    input  logic              clock,
    input  logic              reset,
    booth_mul_iter_if.slave   bus
);
    localparam int AW    = 2 * XLEN + 2;
    localparam int MW    = XLEN + 3;
    localparam int NFULL = XLEN / 2 + 1;
    localparam int CW    = $clog2(NFULL + STEPS + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   areg;
    logic [MW-1:0]   mreg;
    logic [CW-1:0]   cnt;
    logic            mulw_r;
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;

    logic [AW-1:0]   acc_n;
    logic [AW-1:0]   a_n;
    logic [MW-1:0]   m_n;
    logic [CW-1:0]   cnt_n;
    logic [CW-1:0]   n_digits;
    logic            done_now;
    logic [AW-1:0]   a_ext;
    logic [XLEN+1:0] b_ext;
    logic [XLEN-1:0] res_hi_n;
    logic [XLEN-1:0] res_lo_n;
    logic            a_sign;
    logic            b_sign;
    logic            unused_acc_top;

    // 2'b01 (signed multiplier, unsigned multiplicand) is not an RV op; it falls back to unsigned.
    assign a_sign = bus.mul_signed[1];
    assign b_sign = bus.mul_signed[1] & bus.mul_signed[0];

    always_comb begin
        if (bus.mulw) begin
            a_ext = AW'($signed({a_sign & bus.multiplicand[31], bus.multiplicand[31:0]}));
            b_ext = (XLEN+2)'($signed({b_sign & bus.multiplier[31], bus.multiplier[31:0]}));
        end else begin
            a_ext = AW'($signed({a_sign & bus.multiplicand[XLEN-1], bus.multiplicand}));
            b_ext = (XLEN+2)'($signed({b_sign & bus.multiplier[XLEN-1], bus.multiplier}));
        end
    end

    assign n_digits = mulw_r ? CW'(17) : CW'(NFULL);

    // The multiplicand shifts left and the multiplier shifts right by one digit per step,
    // so the Booth window is always mreg[2:0].
    always_comb begin
        acc_n = acc;
        a_n   = areg;
        m_n   = mreg;
        cnt_n = cnt;
        for (int s = 0; s < STEPS; s++) begin
            if (cnt_n < n_digits) begin
                case (m_n[2:0])
                    3'b001, 3'b010: acc_n = acc_n + a_n;
                    3'b011:         acc_n = acc_n + (a_n << 1);
                    3'b100:         acc_n = acc_n - (a_n << 1);
                    3'b101, 3'b110: acc_n = acc_n - a_n;
                    default:        acc_n = acc_n;
                endcase
                a_n   = a_n << 2;
                m_n   = {{2{m_n[MW-1]}}, m_n[MW-1:2]};
                cnt_n = cnt_n + CW'(1);
            end
        end
    end

`ifdef MUL_EARLY_OUT_EN
    assign done_now = (cnt_n >= n_digits) || (m_n == '0) || (m_n == '1);
`else
    assign done_now = (cnt_n >= n_digits);
`endif

    always_comb begin
        if (mulw_r) begin
            res_lo_n = XLEN'($signed(acc_n[31:0]));
            res_hi_n = XLEN'($signed(acc_n[63:32]));
        end else begin
            res_lo_n = acc_n[XLEN-1:0];
            res_hi_n = acc_n[2*XLEN-1:XLEN];
        end
    end

    assign unused_acc_top = ^acc_n[AW-1:2*XLEN];

    always_ff @(posedge clock) begin
        if (reset || bus.flush) begin
            state  <= IDLE;
            acc    <= '0;
            areg   <= '0;
            mreg   <= '0;
            cnt    <= '0;
            mulw_r <= 1'b0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state  <= BUSY;
                        areg   <= a_ext;
                        mreg   <= {b_ext, 1'b0};
                        acc    <= '0;
                        cnt    <= '0;
                        mulw_r <= bus.mulw;
                    end
                end
                BUSY: begin
                    acc  <= acc_n;
                    areg <= a_n;
                    mreg <= m_n;
                    cnt  <= cnt_n;
                    if (done_now) begin
                        state  <= DONE;
                        res_hi <= res_hi_n;
                        res_lo <= res_lo_n;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state  <= IDLE;
                        res_hi <= '0;
                        res_lo <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result_hi = res_hi;
    assign bus.result_lo = res_lo;
    assign bus.state_dbg = state;
endmodule
